// File: rtl/press_game_ctrl.sv
// press_game_ctrl
//   Reaction game controller. A single lit LED sweeps left across eight
//   positions. The player presses BTN while the lit LED sits on TARGET.
//   A correct press scores a hit and every fourth hit raises the sweep speed.
//   A wrong press costs a life. When the last life is lost the game ends
//   until START is pressed again.
//
// Parameters
//   STEP_DIV    clock cycles per LED step at level 0 (>= 8)
//   SHOW_CYC    cycles the judged LED pattern is held (>= 1)
//   TARGET      one-hot winning LED position
//   LIVES_INIT  misses allowed per game (1..7)
//
// Ports
//   CLK          in   sole clock
//   RST_N        in   active-low reset: asserts asynchronously, releases synchronously
//   BTN          in   raw asynchronous player button
//   START        in   raw asynchronous start button
//   LEDS         out  [7:0] LED pattern
//   HIT          out  one-cycle pulse on a correct press (JUDGE only)
//   MISS         out  one-cycle pulse on a wrong press (JUDGE only)
//   SCORE        out  [3:0] hits this game, saturating at 15
//   LEVEL        out  [1:0] speed level 0..3
//   GAME_OVER    out  high while in OVER
//   o_dbg_state  out  [2:0] current FSM state (IDLE=0 SWEEP=1 JUDGE=2 SHOW=3 OVER=4)
//
// Handshakes: none. BTN and START are level inputs; only their rising edges
// act, one clean edge yields exactly one single-cycle internal pulse.

module press_game_ctrl #(
    parameter int          STEP_DIV   = 25_000_000,
    parameter int          SHOW_CYC   = 50_000_000,
    parameter logic [7:0]  TARGET     = 8'b0001_0000,
    parameter int          LIVES_INIT = 3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN,
    input  logic       START,
    output logic [7:0] LEDS,
    output logic       HIT,
    output logic       MISS,
    output logic [3:0] SCORE,
    output logic [1:0] LEVEL,
    output logic       GAME_OVER,
    output logic [2:0] o_dbg_state
);

    localparam int              SCW        = $clog2(STEP_DIV + 1);
    localparam int              SHW        = $clog2(SHOW_CYC + 1);
    localparam logic [SCW-1:0]  STEP_DIV_L = SCW'(STEP_DIV);
    localparam logic [SHW-1:0]  SHOW_LAST  = SHW'(SHOW_CYC - 1);
    localparam logic [2:0]      LIVES_L    = 3'(LIVES_INIT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SWEEP = 3'd1,
        S_JUDGE = 3'd2,
        S_SHOW  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Reset: assertion reaches every flop at once, release is retimed
    // through two flops so all logic leaves reset on the same clock edge.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Button synchronizers and registered rising-edge detectors.
    // [0],[1] are the metastability pair, [2] holds the previous level.
    // ------------------------------------------------------------------
    logic [2:0] r_btn_sync;
    logic [2:0] r_start_sync;
    logic       r_btn_edge;
    logic       r_start_edge;

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_btn_sync   <= 3'b000;
            r_start_sync <= 3'b000;
            r_btn_edge   <= 1'b0;
            r_start_edge <= 1'b0;
        end else begin
            r_btn_sync   <= {r_btn_sync[1:0], BTN};
            r_start_sync <= {r_start_sync[1:0], START};
            r_btn_edge   <= r_btn_sync[1] & ~r_btn_sync[2];
            r_start_edge <= r_start_sync[1] & ~r_start_sync[2];
        end
    end

    // ------------------------------------------------------------------
    // Game state
    // ------------------------------------------------------------------
    state_t         r_state, w_state_nxt;
    logic [7:0]     r_leds, w_leds_nxt;
    logic           r_hit, w_hit_nxt;
    logic           r_miss, w_miss_nxt;
    logic [3:0]     r_score, w_score_nxt;
    logic [1:0]     r_level, w_level_nxt;
    logic [2:0]     r_lives, w_lives_nxt;
    logic           r_game_over, w_game_over_nxt;
    logic [SCW-1:0] r_step_cnt, w_step_cnt_nxt;
    logic [SHW-1:0] r_show_cnt, w_show_cnt_nxt;
    logic [7:0]     r_capture, w_capture_nxt;

    logic [SCW-1:0] w_step_lim;
    logic           w_step_last;
    logic [3:0]     w_score_inc;
    logic           w_new_game;

    assign w_step_lim  = STEP_DIV_L >> r_level;
    assign w_step_last = (r_step_cnt == w_step_lim - SCW'(1));
    assign w_score_inc = (r_score == 4'd15) ? 4'd15 : r_score + 4'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_leds_nxt      = r_leds;
        w_hit_nxt       = 1'b0;
        w_miss_nxt      = 1'b0;
        w_score_nxt     = r_score;
        w_level_nxt     = r_level;
        w_lives_nxt     = r_lives;
        w_game_over_nxt = r_game_over;
        w_step_cnt_nxt  = r_step_cnt;
        w_show_cnt_nxt  = r_show_cnt;
        w_capture_nxt   = r_capture;
        w_new_game      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_leds_nxt      = 8'h00;
                w_game_over_nxt = 1'b0;
                w_new_game      = r_start_edge;
            end

            S_SWEEP: begin
                if (r_btn_edge) begin
                    // The verdict is decided here so that the registered
                    // HIT/MISS/SCORE/LEVEL/lives values are live during the
                    // single JUDGE cycle. LEDS holds still on this edge, so
                    // a simultaneous terminal count keeps the pre-rotate value.
                    w_capture_nxt = r_leds;
                    w_state_nxt   = S_JUDGE;
                    if (r_leds == TARGET) begin
                        w_hit_nxt   = 1'b1;
                        w_score_nxt = w_score_inc;
                        if ((r_score != 4'd15) && (r_level != 2'd3) &&
                            ((w_score_inc == 4'd4) || (w_score_inc == 4'd8) ||
                             (w_score_inc == 4'd12))) begin
                            w_level_nxt = r_level + 2'd1;
                        end
                    end else begin
                        w_miss_nxt = 1'b1;
                        if (r_lives != 3'd0) w_lives_nxt = r_lives - 3'd1;
                    end
                end else if (w_step_last) begin
                    w_leds_nxt     = {r_leds[6:0], r_leds[7]};
                    w_step_cnt_nxt = '0;
                end else begin
                    w_step_cnt_nxt = r_step_cnt + SCW'(1);
                end
            end

            S_JUDGE: begin
                w_show_cnt_nxt = '0;
                if (r_miss && (r_lives == 3'd0)) begin
                    w_state_nxt     = S_OVER;
                    w_leds_nxt      = 8'hFF;
                    w_game_over_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_SHOW;
                    w_leds_nxt  = r_capture;
                end
            end

            S_SHOW: begin
                w_leds_nxt = r_capture;
                if (r_show_cnt == SHOW_LAST) begin
                    w_state_nxt    = S_SWEEP;
                    w_leds_nxt     = 8'h01;
                    w_step_cnt_nxt = '0;
                end else begin
                    w_show_cnt_nxt = r_show_cnt + SHW'(1);
                end
            end

            S_OVER: begin
                w_leds_nxt      = 8'hFF;
                w_game_over_nxt = 1'b1;
                w_new_game      = r_start_edge;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_leds_nxt  = 8'h00;
            end
        endcase

        if (w_new_game) begin
            w_state_nxt     = S_SWEEP;
            w_score_nxt     = 4'd0;
            w_level_nxt     = 2'd0;
            w_lives_nxt     = LIVES_L;
            w_leds_nxt      = 8'h01;
            w_step_cnt_nxt  = '0;
            w_game_over_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= S_IDLE;
            r_leds      <= 8'h00;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
            r_score     <= 4'd0;
            r_level     <= 2'd0;
            r_lives     <= LIVES_L;
            r_game_over <= 1'b0;
            r_step_cnt  <= '0;
            r_show_cnt  <= '0;
            r_capture   <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_leds      <= w_leds_nxt;
            r_hit       <= w_hit_nxt;
            r_miss      <= w_miss_nxt;
            r_score     <= w_score_nxt;
            r_level     <= w_level_nxt;
            r_lives     <= w_lives_nxt;
            r_game_over <= w_game_over_nxt;
            r_step_cnt  <= w_step_cnt_nxt;
            r_show_cnt  <= w_show_cnt_nxt;
            r_capture   <= w_capture_nxt;
        end
    end

    assign LEDS        = r_leds;
    assign HIT         = r_hit;
    assign MISS        = r_miss;
    assign SCORE       = r_score;
    assign LEVEL       = r_level;
    assign GAME_OVER   = r_game_over;
    assign o_dbg_state = r_state;

endmodule

// File: doc/press_game_ctrl.md
PRESS_GAME_CTRL -- requirements
Module: press_game_ctrl

Interface
REQ-001 Parameter STEP_DIV, default 25_000_000, SHALL set clock cycles per LED step at level 0 (legal min 8).
REQ-002 Parameter SHOW_CYC, default 50_000_000, SHALL set cycles the judged LED pattern is held (min 1).
REQ-003 Parameter TARGET, default 8'b0001_0000, SHALL be the one-hot winning LED position.
REQ-004 Parameter LIVES_INIT, default 3, SHALL be misses allowed per game (1..7).
REQ-005 CLK  in  1  sole clock; all state SHALL change on posedge CLK only.
REQ-006 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-007 BTN  in  1  raw asynchronous player button.
REQ-008 START  in  1  raw asynchronous start button.
REQ-009 LEDS  out  8  moving LED pattern.
REQ-010 HIT  out  1  one-cycle pulse on a correct press.
REQ-011 MISS  out  1  one-cycle pulse on a wrong press.
REQ-012 SCORE  out  4  hits this game, saturating at 15.
REQ-013 LEVEL  out  2  speed level 0..3.
REQ-014 GAME_OVER  out  1  high while in OVER.

Function
REQ-015 BTN and START SHALL each pass a 2-flop synchronizer plus a rising-edge detector; only edges act, held levels are ignored.
REQ-016 Edge latency: an input first sampled high at posedge k SHALL produce an edge pulse during cycle k+2..k+3, acted on at posedge k+3.
REQ-017 States SHALL be IDLE, SWEEP, JUDGE, SHOW, OVER.
REQ-018 IDLE: LEDS=0; START edge -> SWEEP with SCORE=0, LEVEL=0, lives=LIVES_INIT, LEDS=8'b0000_0001, step counter=0.
REQ-019 SWEEP: step counter SHALL count 0..(STEP_DIV>>LEVEL)-1; at terminal count LEDS SHALL rotate left by one (bit7 wraps to bit0) and the counter SHALL clear.
REQ-020 SWEEP: BTN edge SHALL capture the currently displayed LEDS into a capture register and go to JUDGE; LEDS SHALL not rotate on that cycle.
REQ-021 BTN edge and step terminal count in the same cycle: capture SHALL take the pre-rotate value.
REQ-022 JUDGE (exactly 1 cycle): capture==TARGET -> HIT=1, SCORE+1 (held at 15 if already 15); else MISS=1, lives-1.
REQ-023 JUDGE: a hit bringing SCORE to 4, 8 or 12 SHALL increment LEVEL; LEVEL SHALL never exceed 3.
REQ-024 JUDGE next state: miss with lives reaching 0 -> OVER; otherwise -> SHOW.
REQ-025 SHOW: LEDS SHALL show the captured value for SHOW_CYC cycles, then -> SWEEP with LEDS=8'b0000_0001 and step counter=0.
REQ-026 BTN edges in JUDGE, SHOW, IDLE, OVER SHALL be discarded, not queued.
REQ-027 START edges SHALL be ignored in SWEEP, JUDGE, SHOW.
REQ-028 OVER: LEDS=8'hFF, GAME_OVER=1, SCORE/LEVEL held; START edge -> same new-game init as REQ-018.
REQ-029 HIT and MISS SHALL never be high together and SHALL be high only in JUDGE.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 RST_N low SHALL immediately force IDLE, LEDS=0, HIT=0, MISS=0, SCORE=0, LEVEL=0, GAME_OVER=0, lives=LIVES_INIT, all counters, synchronizers and capture register to 0.
REQ-032 Reset mid-game (any state) SHALL abandon the game with no HIT/MISS pulse; release SHALL resume in IDLE, awaiting a fresh START edge.
REQ-033 Deassertion SHALL be synchronized to CLK.

Verification (STEP_DIV=8, SHOW_CYC=4, LIVES_INIT=3)
REQ-034 START pulse, no BTN -> LEDS 01,02,04..80,01 changing every 8 cycles; no HIT/MISS.
REQ-035 BTN edge while LEDS=8'h10 -> one HIT, SCORE=1, LEDS=8'h10 for 4 cycles, then sweep restarts at 8'h01.
REQ-036 Four hits -> LEVEL=1, step period 4 cycles; twelve hits -> LEVEL=3, period 1; sixteen hits -> SCORE stays 15.
REQ-037 Three presses on 8'h02 -> three MISS pulses, then GAME_OVER=1, LEDS=8'hFF; START -> SCORE=0, LEDS=8'h01.
REQ-038 BTN held high 100 cycles -> exactly one judgement; BTN edge during SHOW -> no effect.
REQ-039 RST_N low during SHOW -> LEDS=0, SCORE=0 asynchronously; BTN after release -> no response until START.
